// File: rtl/acc_arbiter_if.sv
// acc_arbiter_if: requester-side and accumulator-side signals of the shared accumulator arbiter
interface acc_arbiter_if #(
    parameter int m    = 4,
    parameter int n    = 4,
    parameter int k    = 10,
    parameter int nreq = 4
);
    localparam int width  = m + n;
    localparam int swidth = $clog2(k * (2 ** (m + n) - 1));

    logic [nreq-1:0]         req;
    logic [nreq*k*width-1:0] din_all;
    logic [nreq-1:0]         gnt;
    logic [nreq-1:0]         done;
    logic                    err;
    logic [swidth-1:0]       result;
    logic                    acc_pl;
    logic [k*width-1:0]      acc_din;
    logic                    acc_ready;
    logic [swidth-1:0]       acc_sum;

    modport master (
        output req, din_all, acc_ready, acc_sum,
        input  gnt, done, err, result, acc_pl, acc_din
    );

    modport slave (
        input  req, din_all, acc_ready, acc_sum,
        output gnt, done, err, result, acc_pl, acc_din
    );
endinterface

// File: rtl/acc_arbiter.sv
// acc_arbiter: round-robin sharing of one accumulator among nreq requesters, with a BUSY watchdog
module acc_arbiter #(
    parameter int m    = 4,
    parameter int n    = 4,
    parameter int k    = 10,
    parameter int nreq = 4,
    parameter int tmo  = 64
) (
    input logic        clk,
    input logic        rstn,
    acc_arbiter_if.slave bus
);
    localparam int width  = m + n;
    localparam int swidth = $clog2(k * (2 ** (m + n) - 1));
    localparam int twidth = $clog2(tmo + 1);
    localparam int pw     = (nreq > 1) ? $clog2(nreq) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t             state, state_n;
    logic [pw-1:0]      ptr, ptr_n, win;
    logic [twidth-1:0]  tcnt, tcnt_n;
    logic               any;
    logic [nreq-1:0]    gnt_n, done_n;
    logic               err_n, pl_n;
    logic [swidth-1:0]  result_n;
    logic [k*width-1:0] din_n;

    function automatic logic [pw-1:0] wrap(input int v);
        return pw'(v % nreq);
    endfunction

    // Round-robin pick: scan from ptr+nreq down to ptr+1 so the nearest requester after ptr wins last
    always_comb begin
        win = ptr;
        any = 1'b0;
        for (int i = nreq; i >= 1; i--) begin
            if (bus.req[wrap(int'(ptr) + i)]) begin
                win = wrap(int'(ptr) + i);
                any = 1'b1;
            end
        end
    end

    // Next state and next register values; arbitration only acts outside BUSY
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        tcnt_n   = tcnt;
        gnt_n    = bus.gnt;
        done_n   = '0;
        err_n    = 1'b0;
        result_n = bus.result;
        pl_n     = bus.acc_pl;
        din_n    = bus.acc_din;
        if (state == BUSY) begin
            tcnt_n = tcnt + 1'b1;
            if (bus.acc_ready || tcnt == twidth'(tmo - 1)) begin
                state_n  = GAP;
                done_n   = bus.gnt;
                err_n    = !bus.acc_ready;
                result_n = bus.acc_ready ? bus.acc_sum : '0;
                pl_n     = 1'b0;
            end
        end else if (any) begin
            state_n = BUSY;
            gnt_n   = nreq'(1) << win;
            din_n   = bus.din_all[int'(win)*k*width +: k*width];
            pl_n    = 1'b1;
            tcnt_n  = '0;
            ptr_n   = win;
        end else begin
            state_n = IDLE;
            gnt_n   = '0;
        end
    end

    // State and output registers; reset discards any job in flight without a done pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            ptr         <= pw'(nreq - 1);
            tcnt        <= '0;
            bus.gnt     <= '0;
            bus.done    <= '0;
            bus.err     <= 1'b0;
            bus.result  <= '0;
            bus.acc_pl  <= 1'b0;
            bus.acc_din <= '0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            tcnt        <= tcnt_n;
            bus.gnt     <= gnt_n;
            bus.done    <= done_n;
            bus.err     <= err_n;
            bus.result  <= result_n;
            bus.acc_pl  <= pl_n;
            bus.acc_din <= din_n;
        end
    end
endmodule

// File: tb/tb_acc_arbiter.sv
// tb_acc_arbiter: scoreboard bench with requester, accumulator and round-robin reference models
module tb_acc_arbiter;
    localparam int m      = 4;
    localparam int n      = 4;
    localparam int k      = 10;
    localparam int nreq   = 4;
    localparam int tmo    = 64;
    localparam int width  = m + n;
    localparam int swidth = $clog2(k * (2 ** (m + n) - 1));

    typedef struct {
        int id;
        int sum;
        bit e;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    acc_arbiter_if #(.m(m), .n(n), .k(k), .nreq(nreq)) bus();

    acc_arbiter #(.m(m), .n(n), .k(k), .nreq(nreq), .tmo(tmo)) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int grant_cyc = 0;
    int model_ptr = nreq - 1;
    int need[nreq];
    int nxt = -2;
    int acnt = 0;
    int alat = 1;
    int asum = 0;
    bit go = 1'b0;
    bit stall = 1'b0;
    bit pl_seen = 1'b0;
    logic [width-1:0] vec[nreq][k];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sum_vec(input int i);
        int s = 0;
        for (int w = 0; w < k; w++) s += int'(vec[i][w]);
        return s;
    endfunction

    always @(posedge clk) cyc++;

    // Requesters: raise req on a new phase, drop it once the last needed grant is seen, scramble idle slices
    always @(negedge clk) begin
        if (!rstn) begin
            bus.req = '0;
            for (int i = 0; i < nreq; i++) need[i] = 0;
        end else if (go) begin
            for (int i = 0; i < nreq; i++) begin
                if (need[i] > 0) begin
                    for (int w = 0; w < k; w++) bus.din_all[(i*k+w)*width +: width] = vec[i][w];
                    bus.req[i] = 1'b1;
                end
            end
            go = 1'b0;
        end else begin
            if (bus.acc_pl && !pl_seen) begin
                for (int i = 0; i < nreq; i++) begin
                    if (bus.gnt[i]) begin
                        need[i]--;
                        if (need[i] <= 0) bus.req[i] = 1'b0;
                    end
                end
                grant_cyc = cyc;
            end
            for (int i = 0; i < nreq; i++)
                if (!bus.req[i])
                    for (int w = 0; w < k; w++) bus.din_all[(i*k+w)*width +: width] = width'($urandom);
        end
        pl_seen = bus.acc_pl;
    end

    // Accumulator stand-in: answers after a random latency with the sum of the presented words
    always @(negedge clk) begin
        if (bus.acc_pl && !stall) begin
            acnt++;
            asum = 0;
            for (int w = 0; w < k; w++) asum += int'(bus.acc_din[w*width +: width]);
            bus.acc_sum = swidth'(asum);
            bus.acc_ready = (acnt == alat);
        end else begin
            acnt = 0;
            bus.acc_ready = 1'b0;
            alat = int'($urandom_range(1, 8));
        end
    end

    // Monitor: pops the scoreboard on each done pulse and checks the following cycle
    always @(negedge clk) begin
        if (!rstn) begin
            nxt = -2;
        end else begin
            checks++;
            if (!$onehot0(bus.gnt)) begin
                errors++;
                $display("FAIL gnt_onehot: got %b expected at most one bit", bus.gnt);
            end
            if (nxt != -2) begin
                chk("done_pulse_width", int'(bus.done), 0);
                chk("err_pulse_width", int'(bus.err), 0);
                if (nxt >= 0) begin
                    chk("b2b_gnt", int'(bus.gnt), 1 << nxt);
                    chk("b2b_pl", int'(bus.acc_pl), 1);
                end
                nxt = -2;
            end
            if (bus.done != '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=%b expected none", bus.done);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_id", int'(bus.done), 1 << mon_e.id);
                    chk("gnt_at_done", int'(bus.gnt), 1 << mon_e.id);
                    chk("err", int'(bus.err), int'(mon_e.e));
                    chk("result", int'(bus.result), mon_e.sum);
                    chk("pl_low_in_gap", int'(bus.acc_pl), 0);
                    if (mon_e.e) chk("timeout_latency", cyc - grant_cyc, tmo);
                    nxt = (sb.size() > 0) ? sb[0].id : -1;
                end
            end
        end
    end

    task automatic wait_empty();
        for (int c = 0; c < 3000 && sb.size() > 0; c++) @(negedge clk);
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL phase_timeout: got %0d outstanding jobs expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Reference: serve pending jobs in rotating order starting after the last served requester
    task automatic run_phase(input int n0, input int n1, input int n2, input int n3,
                             input bit keep_vec, input bit chk_lat);
        int nd[nreq];
        int left[nreq];
        int tot;
        int first;
        exp_t x;
        nd = '{n0, n1, n2, n3};
        left = nd;
        tot = n0 + n1 + n2 + n3;
        if (!keep_vec)
            for (int i = 0; i < nreq; i++)
                for (int w = 0; w < k; w++) vec[i][w] = width'($urandom);
        while (tot > 0) begin
            for (int d = 1; d <= nreq; d++) begin
                int i;
                i = (model_ptr + d) % nreq;
                if (left[i] > 0) begin
                    x.id = i;
                    x.e = stall;
                    x.sum = stall ? 0 : sum_vec(i);
                    sb.push_back(x);
                    left[i]--;
                    tot--;
                    model_ptr = i;
                    break;
                end
            end
        end
        first = (sb.size() > 0) ? sb[0].id : 0;
        @(posedge clk);
        #2;
        for (int i = 0; i < nreq; i++) need[i] = nd[i];
        go = 1'b1;
        if (chk_lat) begin
            @(negedge clk);
            @(negedge clk);
            chk("grant_latency_gnt", int'(bus.gnt), 1 << first);
            chk("grant_latency_pl", int'(bus.acc_pl), 1);
        end
        wait_empty();
    endtask

    initial begin
        bus.req = '0;
        bus.din_all = '0;
        bus.acc_ready = 1'b0;
        bus.acc_sum = '0;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_result", int'(bus.result), 0);
        chk("rst_pl", int'(bus.acc_pl), 0);
        chk("rst_din_zero", int'(bus.acc_din == '0), 1);

        for (int i = 0; i < nreq; i++)
            for (int w = 0; w < k; w++) vec[i][w] = 8'hFF;
        chk("ff_vector_sum", sum_vec(2), 2550);
        run_phase(0, 0, 1, 0, 1'b1, 1'b1);

        run_phase(1, 1, 1, 1, 1'b0, 1'b1);
        run_phase(1, 1, 1, 1, 1'b0, 1'b0);
        run_phase(10, 10, 0, 0, 1'b0, 1'b1);

        stall = 1'b1;
        run_phase(0, 0, 0, 1, 1'b0, 1'b1);
        stall = 1'b0;
        run_phase(0, 0, 1, 0, 1'b0, 1'b1);

        repeat (6) run_phase(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
        run_phase(1, 0, 0, 0, 1'b0, 1'b0);

        stall = 1'b1;
        for (int w = 0; w < k; w++) vec[2][w] = width'($urandom);
        @(posedge clk);
        #2;
        need[2] = 1;
        go = 1'b1;
        repeat (6) @(negedge clk);
        chk("pre_reset_gnt", int'(bus.gnt), 4);
        chk("pre_reset_result_nonzero", int'(bus.result != '0), 1);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("async_rst_gnt", int'(bus.gnt), 0);
        chk("async_rst_pl", int'(bus.acc_pl), 0);
        chk("async_rst_done", int'(bus.done), 0);
        chk("async_rst_result", int'(bus.result), 0);
        sb.delete();
        model_ptr = nreq - 1;
        stall = 1'b0;
        @(posedge clk);
        #3 rstn = 1'b1;
        @(negedge clk);
        run_phase(0, 1, 0, 0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/acc_arbiter.md
# acc_arbiter

Round-robin arbiter and sequencer that shares one `accumulator` instance (parameters `m`, `n`, `k`) among `nreq` requesters. It grants one requester at a time and latches that requester's k-word vector. It drives the accumulator's `pl`/`din` handshake, waits for `ready`, and returns the sum to the granted requester with a one-cycle `done` pulse. A watchdog aborts a job whose `ready` never arrives.

## Interface
- `m`, 4, multiplicand width component; word width is `width = m+n`
- `n`, 4, multiplier width component
- `k`, 10, words per job
- `nreq`, 4, number of requesters (≥2)
- `tmo`, 64, BUSY cycles allowed before abort (≥ k+2)
- localparam `swidth` = $clog2(k*(2**(m+n)-1)), the same formula as the accumulator
- localparam `twidth` = $clog2(tmo+1)

Ports:
- `clk`  in  1  single clock, rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `req`  in  nreq  per-requester job request, level
- `din_all`  in  nreq*k*width  requester i's vector at `[i*k*width +: k*width]`
- `gnt`  out  nreq  one-hot grant, registered
- `done`  out  nreq  one-cycle completion pulse to the granted requester
- `err`  out  1  one-cycle pulse coincident with `done` when the job timed out
- `result`  out  swidth  last completed sum; held until the next completion
- `acc_pl`  out  1  to accumulator `pl`
- `acc_din`  out  k*width  to accumulator `din`
- `acc_ready`  in  1  from accumulator `ready`
- `acc_sum`  in  swidth  from accumulator `sum`

## Operation
- The FSM has three states: IDLE, BUSY and GAP.
- **Arbitration** is combinational over `req` and `ptr` (last-served index). Priority starts at `ptr+1` mod nreq and wraps. It is evaluated only in IDLE and GAP.
- **IDLE**, any `req` set: at the next edge
  - `gnt` gets the one-hot winner and `acc_din` latches the winner's slice of `din_all`.
  - `acc_pl` goes 1, `tcnt` goes 0, `ptr` gets the winner, and the FSM moves to BUSY.
- **BUSY**: `acc_pl` is held at 1 and `acc_din` is held stable. `tcnt` increments every cycle.
  - If `acc_ready`=1 at an edge: `result` gets `acc_sum`, `done[winner]` goes 1, `acc_pl` goes 0, and the FSM moves to GAP.
  - Otherwise, if `tcnt`==tmo-1: `result` gets 0, `done[winner]` goes 1, `err` goes 1, `acc_pl` goes 0, and the FSM moves to GAP.
  - `acc_ready` takes precedence over timeout in the same cycle.
- **GAP** lasts exactly one cycle.
  - `done`/`err` are high and `gnt` is still asserted. `acc_pl` is 0, which guarantees at least one low cycle between jobs.
  - At the next edge, `done`/`err` clear and `gnt` clears or is replaced.
  - If any `req` is set, the arbiter grants the next winner straight into BUSY. Otherwise it returns to IDLE.
- **Requester contract**:
  - `din_all` slice must be valid in the cycle `req` is sampled with the grant decision. It may change afterwards.
  - `req` may drop once `gnt` is seen.
  - A `req` still high during the requester's own GAP makes it eligible again, but at the lowest priority because `ptr` already points to it.
- **Reset**: on `rstn`=0, immediately and regardless of clock, the outputs and registers take these values:
  - FSM to IDLE; `gnt`=0, `done`=0, `err`=0, `result`=0.
  - `acc_pl`=0, `acc_din`=0, `tcnt`=0.
  - `ptr`=nreq-1, so requester 0 wins first after reset.
- **Reset mid-job**: the job is discarded with no `done`. The requester must re-request.

## Timing
- Grant latency: request sampled in IDLE → `gnt`/`acc_pl` high the next cycle.
- Completion: `done` high the cycle after the edge where `acc_ready`=1 is sampled.
- Back-to-back throughput: one GAP cycle between jobs. There is no IDLE cycle when a request is pending.
- The timeout fires on the tmo-th BUSY cycle counted from grant.
- `gnt` is never all-ones-but-one or multi-hot. At most one bit is set at any time.

## Test plan
- **Single requester**: k=10, all words 8'hFF on req[2], after reset → `gnt`=4'b0100 one cycle later, `acc_pl`=1 until ready, `done`=4'b0100, `result`=2550, `err`=0.
- **All requesters at once**: `req`=4'b1111 held, each with random vectors → grants in order 0,1,2,3. Each `done` comes once with its correct sum. There is exactly one `acc_pl`-low cycle between jobs.
- **Alternation**: req[0] and req[1] held continuously → grant sequence 0,1,0,1,… with no starvation over 20 jobs.
- **Timeout**: accumulator model holds `acc_ready`=0 and req[3] is set → after tmo=64 BUSY cycles, `done[3]`=1, `err`=1, `result`=0, `acc_pl`=0. The next request is served normally.
- **Input change after grant**: `din_all` is changed every cycle after the grant → `result` equals the sum of the vector captured at grant.
- **Reset during BUSY**: `rstn` is pulsed low mid-job → `gnt`, `acc_pl`, `done`, `result` go to 0 without waiting for a clock edge. After release, a held req[1] is granted with requester 0 idle, and the sum is correct.
